// File: rtl/koto_live_pkg.sv
// Shared definitions for the heartbeat link: state encoding and the nominal
// half-period / tolerance used by both the live generator and the monitor.
package koto_live_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        ALIVE   = 2'd2
    } live_state_t;

    localparam int DEF_CNT_W       = 30;
    localparam int DEF_HALF_PERIOD = 2**29;
    localparam int DEF_TOL         = 2**24;
    localparam int DEF_LOCK_N      = 3;
    localparam int DEF_LOSTC_W     = 16;

endpackage

// File: rtl/live_monitor_if.sv
// Heartbeat cable input plus link-status outputs of the monitor.
interface live_monitor_if #(
    parameter int CNT_W   = koto_live_pkg::DEF_CNT_W,
    parameter int LOSTC_W = koto_live_pkg::DEF_LOSTC_W
);
    logic               live_in;
    logic               alive;
    logic               lost_pulse;
    logic               bad_half_pulse;
    logic [CNT_W-1:0]   last_half;
    logic [LOSTC_W-1:0] lost_count;

    modport master (
        output live_in,
        input  alive, lost_pulse, bad_half_pulse, last_half, lost_count
    );

    modport slave (
        input  live_in,
        output alive, lost_pulse, bad_half_pulse, last_half, lost_count
    );
endinterface

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser for an asynchronous cable input; toggle flags a
// change of the synchronised level (both polarities).
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic toggle
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign toggle = s2 ^ s3;
endmodule

// File: rtl/live_monitor.sv
// Measures every half-period of the remote heartbeat and qualifies the link
// as alive after LOCK_N consecutive in-tolerance halves.
module live_monitor
    import koto_live_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_N      = DEF_LOCK_N,
    parameter int LOSTC_W     = DEF_LOSTC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    live_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] N_LO    = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] N_HI    = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] N_TMO   = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam int               GC_W    = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(LOCK_N - 1);

    logic               toggle;
    logic               good;
    logic               timeout;
    live_state_t        state;
    logic [CNT_W-1:0]   half_cnt;
    logic [GC_W-1:0]    good_cnt;
    logic               alive_q;
    logic               lost_q;
    logic               bad_q;
    logic [CNT_W-1:0]   last_half_q;
    logic [LOSTC_W-1:0] lost_count_q;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (bus.live_in),
        .toggle (toggle)
    );

    // half_cnt equals the length of the half just ended when toggle is high;
    // at the timeout value it is already out of window, so edge priority holds.
    assign good    = (half_cnt >= N_LO) && (half_cnt <= N_HI);
    assign timeout = !toggle && (half_cnt == N_TMO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SEARCH;
            half_cnt     <= '0;
            good_cnt     <= '0;
            alive_q      <= 1'b0;
            lost_q       <= 1'b0;
            bad_q        <= 1'b0;
            last_half_q  <= '0;
            lost_count_q <= '0;
        end else begin
            lost_q <= 1'b0;
            bad_q  <= 1'b0;

            if (toggle)
                half_cnt <= CNT_W'(1);
            else if (half_cnt != '1)
                half_cnt <= half_cnt + 1'b1;

            // The first edge seen in SEARCH only marks a phase reference.
            if (toggle && state != SEARCH)
                last_half_q <= half_cnt;

            case (state)
                SEARCH: begin
                    if (toggle) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (toggle) begin
                        if (good) begin
                            if (good_cnt == GC_LAST) begin
                                state    <= ALIVE;
                                alive_q  <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            bad_q    <= 1'b1;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state <= SEARCH;
                    end
                end
                ALIVE: begin
                    if (toggle && !good) begin
                        bad_q    <= 1'b1;
                        lost_q   <= 1'b1;
                        alive_q  <= 1'b0;
                        state    <= MEASURE;
                        good_cnt <= '0;
                        if (lost_count_q != '1)
                            lost_count_q <= lost_count_q + 1'b1;
                    end else if (timeout) begin
                        lost_q  <= 1'b1;
                        alive_q <= 1'b0;
                        state   <= SEARCH;
                        if (lost_count_q != '1)
                            lost_count_q <= lost_count_q + 1'b1;
                    end
                end
                default: begin
                    state   <= SEARCH;
                    alive_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alive          = alive_q;
    assign bus.lost_pulse     = lost_q;
    assign bus.bad_half_pulse = bad_q;
    assign bus.last_half      = last_half_q;
    assign bus.lost_count     = lost_count_q;
endmodule
